mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (IF) and load/store (LS).
//  Sits between PC/imem-side fetch logic and the dmem-side load/store path.
//  Gives grants, tracks one outstanding access over a fixed memory latency, and returns read data.
//  LS has priority over IF; a starvation guard bounds IF wait time.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width, all ports
//  MEM_LAT     2   cycles from mem_en to valid mem_rdata; legal range 1..15
//  STARVE_MAX  4   consecutive LS grants with if_req pending before IF is forced to win; >=1
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, synchronous, active-low
//  if_req     in   1       fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       fetch accepted this cycle
//  if_rvalid  out  1       fetch data valid, 1-cycle pulse
//  if_rdata   out  DATA_W  fetch data; 0 when if_rvalid=0
//  ls_req     in   1       load/store request; held with ls_we/addr/wdata until ls_gnt
//  ls_we      in   1       1=store, 0=load
//  ls_addr    in   ADDR_W  load/store address
//  ls_wdata   in   DATA_W  store data
//  ls_gnt     out  1       load/store accepted this cycle
//  ls_rvalid  out  1       completion pulse: load data valid, or store done
//  ls_rdata   out  DATA_W  load data; 0 on stores and when ls_rvalid=0
//  mem_en     out  1       memory access issue strobe
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  Reset (rst=0 at clk edge):
//   - cnt_q=0, owner_q=IF, we_q=0, starve_q=0.
//   - All outputs 0. An in-flight access is dropped and produces no rvalid.
//  Occupancy: 4-bit cnt_q.
//   - Arbiter is free when cnt_q<=1.
//   - A grant loads cnt_q=MEM_LAT. Otherwise cnt_q decrements while nonzero.
//  Grant (combinational, only when free; at most one gnt per cycle):
//   - ls_req && !(if_req && starve_q==STARVE_MAX) -> ls_gnt.
//   - Else if_req -> if_gnt.
//  Issue, same cycle as the grant:
//   - mem_en=1.
//   - mem_addr and mem_wdata come from the winner. mem_wdata=0 for IF.
//   - mem_we = ls_we for LS, 0 for IF.
//   - When mem_en=0: mem_we, mem_addr and mem_wdata are 0.
//  Completion:
//   - When cnt_q==1, pulse <owner_q>_rvalid.
//   - rdata = mem_rdata for reads, 0 for stores.
//  Latency and throughput:
//   - Grant at cycle T -> rvalid at T+MEM_LAT.
//   - A new grant may issue in the rvalid cycle.
//   - Throughput is 1 access per MEM_LAT cycles; MEM_LAT=1 allows back-to-back every cycle.
//  Starvation counter starve_q (saturating):
//   - +1 on each ls_gnt while if_req=1.
//   - Cleared on if_gnt, or on any cycle with if_req=0.
//  Simultaneous events:
//   - Rvalid of the old access and grant of the new one in the same cycle are both legal.
//   - owner_q/we_q update at the edge ending that cycle.
//  Requests arriving while busy:
//   - Not granted and not queued.
//   - The requester keeps req asserted; no overflow is possible.
//  Protocol violation (req dropped before gnt): the request is ignored, with no side effects.
// STRUCTURE
//  Package rv32_mem_pkg:
//   - typedef owner_e {OWN_IF, OWN_LS}
//   - localparam CNT_W=4
//   - the MEM_LAT legal-range check
//  Sub-module mem_arb_pick:
//   - combinational priority and starvation pick
//   - inputs: free, if_req, ls_req, starve_q
//   - outputs: if_gnt, ls_gnt
//  Top level holds cnt_q, owner_q, we_q, starve_q and the issue/return muxes.
// TESTING
//  1 MEM_LAT=2, if_req only, if_addr=0x100, mem returns 0xDEADBEEF
//    -> if_gnt@T, mem_en@T, if_rvalid/if_rdata=0xDEADBEEF@T+2.
//  2 if_req and ls_req (load 0x200) both asserted at T
//    -> ls_gnt@T, if_gnt@T+2, ls_rvalid@T+2, if_rvalid@T+4.
//  3 Store ls_we=1, ls_addr=0x40, ls_wdata=0x12345678
//    -> mem_we=1, mem_wdata=0x12345678@T, ls_rvalid@T+2 with ls_rdata=0.
//  4 STARVE_MAX=4, ls_req and if_req held high continuously
//    -> 4 ls_gnt, then if_gnt, and the pattern repeats; if_rvalid never missing.
//  5 MEM_LAT=1, ls_req held high for 5 cycles
//    -> 5 consecutive ls_gnt, ls_rvalid each cycle T+1..T+5.
//  6 rst=0 one cycle after a grant
//    -> all outputs 0 next cycle, no rvalid for that access, a fresh grant is possible after release.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package rv32_mem_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam int CNT_W = 4;

    // The occupancy counter is CNT_W bits wide and a latency of 0 has no meaning.
    function automatic bit mem_lat_ok(input int lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: fixed LS-over-IF priority pick with a starvation override for IF.
// Latency: purely combinational, grants in the same cycle as the request.
// Backpressure: no grant unless free; losers simply keep their request asserted.
module mem_arb_pick #(
    parameter int STARVE_MAX = 4,
    parameter int STARVE_W   = 3
) (
    input  logic                free,
    input  logic                if_req,
    input  logic                ls_req,
    input  logic [STARVE_W-1:0] starve_q,
    output logic                if_gnt,
    output logic                ls_gnt
);

    logic if_starved;

    always_comb begin
        if_starved = if_req && (starve_q == STARVE_W'(STARVE_MAX));
        ls_gnt     = free && ls_req && !if_starved;
        if_gnt     = free && if_req && !ls_gnt;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port memory between fetch (IF) and load/store (LS).
// Latency: grant and issue in the same cycle, rvalid exactly MEM_LAT cycles later.
// Backpressure: one access in flight; requesters hold req until gnt, nothing is queued.
module mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
        $error("mem_arbiter: MEM_LAT must be in 1..15");
    end
    if (STARVE_MAX < 1) begin : g_bad_starve
        $error("mem_arbiter: STARVE_MAX must be at least 1");
    end

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    owner_e              owner_q, owner_d;
    logic                we_q, we_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                free;
    logic                done;
    logic                gnt_any;

    // Reset gates grants and completions so every output is quiet while rst is low.
    assign free    = rst && (cnt_q <= CNT_W'(1));
    assign done    = rst && (cnt_q == CNT_W'(1));
    assign gnt_any = if_gnt || ls_gnt;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (STARVE_W)
    ) u_pick (
        .free     (free),
        .if_req   (if_req),
        .ls_req   (ls_req),
        .starve_q (starve_q),
        .if_gnt   (if_gnt),
        .ls_gnt   (ls_gnt)
    );

    always_comb begin
        mem_en    = gnt_any;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ls_gnt) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        if_rvalid = done && (owner_q == OWN_IF);
        ls_rvalid = done && (owner_q == OWN_LS);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = (ls_rvalid && !we_q) ? mem_rdata : '0;
    end

    always_comb begin
        cnt_d    = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : cnt_q;
        owner_d  = owner_q;
        we_d     = we_q;
        starve_d = starve_q;
        if (gnt_any) begin
            cnt_d   = CNT_W'(MEM_LAT);
            owner_d = ls_gnt ? OWN_LS : OWN_IF;
            we_d    = ls_gnt && ls_we;
        end
        // Saturating count of LS wins that IF had to sit through.
        if (if_gnt || !if_req) begin
            starve_d = '0;
        end else if (ls_gnt && (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            starve_q <= starve_d;
        end
    end

endmodule
